gpio_in_debounce: RTL and testbench
===================================

// Module: gpio_in_debounce
// PURPOSE
//  Input conditioner between the board slide switches and the core's GPIO_i bus.
//  Per-bit 2-FF synchronizer plus counter debouncer, running on the fast PLL clock.
//  Snapshots the debounced word on each divider sample strobe, so the core sees a
//  bus that stays stable for a whole slow-clock period, and flags changes since the
//  previous snapshot.
// PARAMETERS
//  WIDTH            8        number of GPIO input bits
//  DEBOUNCE_CYCLES  500000   consecutive stable clk cycles needed to accept a new level (>=2)
//  CNT_W            $clog2(DEBOUNCE_CYCLES)  debounce counter width (derived, do not override)
// PORTS
//  clk        in   1      fast PLL clock, same clock that drives the divider
//  rst        in   1      asynchronous reset, active-low
//  sw_i       in   WIDTH  raw asynchronous switch levels
//  sample_i   in   1      one-cycle strobe in clk domain (divider RCO)
//  gpio_o     out  WIDTH  debounced snapshot to core GPIO_i
//  stable_o   out  WIDTH  live debounced level, not snapshotted
//  changed_o  out  1      high for the snapshot period when gpio_o differs from the previous snapshot
//  busy_o     out  1      OR of all bits whose counter is nonzero (a bit is settling)
// BEHAVIOUR
//  - Reset (rst=0, async): sync FFs, stable_o, gpio_o, counters = 0; changed_o = 0; busy_o = 0.
//  - Sync: sw_i passes through two flops -> s2. Latency from sw_i to s2 is 2 clk.
//  - Per bit, each clk:
//    - s2 == stable: counter <= 0.
//    - s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
//    - otherwise: counter <= counter+1.
//  - Result: a clean edge appears on stable_o exactly 2+DEBOUNCE_CYCLES clk after sw_i changes.
//  - A glitch shorter than DEBOUNCE_CYCLES clk resets the counter and never reaches stable_o.
//  - Counter saturates only by the accept rule above; it never wraps.
//  - Snapshot: on sample_i=1, gpio_o <= stable_o (the value from the same cycle, before any update
//    in that cycle) and changed_o <= (stable_o != gpio_o). Both hold until the next sample_i.
//  - sample_i in the same cycle as a stable_o flip: the snapshot takes the pre-flip value.
//    The flip is reported at the next sample.
//  - Back-to-back sample_i on consecutive cycles is legal. Each one re-evaluates changed_o.
//  - Reset mid-debounce discards the partial count. After release, a held switch is re-accepted
//    only after the full 2+DEBOUNCE_CYCLES.
//  - Bits are fully independent. Several bits may flip in the same cycle.
// CONFIGURATION
//  - GPIO_EDGE_EN defined:
//    - adds output edge_o (WIDTH): sticky per-bit flag, set in the cycle a bit's stable level flips
//      in either direction.
//    - On sample_i, the current flags are copied into an edge_snap register driven on edge_o and the
//      sticky flags clear. A flip in the same cycle as sample_i is kept in sticky for the next snapshot.
//    - Reset value of edge_o is 0.
//  - GPIO_EDGE_EN undefined: no edge_o port and no edge logic. All other behaviour is identical.
// STRUCTURE
//  - Shared package gpio_pkg: GPIO_WIDTH=8 default and a debounce-cycles constant for the 50 MHz board.
//    It is reused by the LED output stage.
//  - One sub-module, gpio_debounce_bit (ports clk, rst, d_i, stable_o, busy_o; parameter DEBOUNCE_CYCLES).
//    It is instanced WIDTH times in a generate loop.
//  - Snapshot, changed_o and edge logic stay in the top.
// TESTING (sim with WIDTH=8, DEBOUNCE_CYCLES=4)
//  1. Reset, then sw_i=8'hA5 held -> stable_o=8'hA5 exactly 6 clk after the change; busy_o high cycles 3..5.
//     Next sample_i -> gpio_o=8'hA5, changed_o=1.
//  2. Bit0 glitch 1->0->1 lasting 3 clk -> stable_o[0] never changes, busy_o pulses, changed_o=0 at next sample.
//  3. sample_i in the cycle stable_o goes 00->01 -> gpio_o=00, changed_o=0. Next sample -> gpio_o=01, changed_o=1.
//  4. Two samples with no input change -> second gives changed_o=0, gpio_o unchanged.
//  5. Assert rst low mid-debounce (counter=2) -> all outputs 0 asynchronously.
//     After release, input is accepted only after the full 6 clk.
//  6. GPIO_EDGE_EN: bit3 goes 0->1->0 between samples -> edge_o=8'h08 after the sample, then 8'h00
//     after the following sample.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared GPIO constants for the board input conditioner and the LED output stage.
package gpio_pkg;

  localparam int GPIO_WIDTH = 8;
  // 10 ms of switch settling time at the 50 MHz board clock
  localparam int GPIO_DEBOUNCE_50MHZ = 500000;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input bit: 2-FF synchronizer followed by a stable-count debouncer.
import gpio_pkg::*;

module gpio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_50MHZ,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic stable_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_p0;
  logic             s2_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_p0    <= 1'b0;
      s2_p1    <= 1'b0;
      stable_o <= 1'b0;
      cnt      <= '0;
    end else begin
      // synchronizer stages
      s1_p0 <= d_i;
      s2_p1 <= s1_p0;
      // accept the new level only after DEBOUNCE_CYCLES consecutive mismatches
      if (s2_p1 == stable_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable_o <= s2_p1;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy_o = |cnt;

endmodule

// File: rtl/gpio_in_debounce.sv
// Switch input conditioner: per-bit debounce, slow-clock snapshot and change flag.
// Optional per-bit sticky edge reporting on edge_o when GPIO_EDGE_EN is defined.
import gpio_pkg::*;

module gpio_in_debounce #(
  parameter int WIDTH           = GPIO_WIDTH,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_50MHZ,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_i,
  input  logic             sample_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] stable_o,
  output logic             changed_o,
`ifdef GPIO_EDGE_EN
  output logic [WIDTH-1:0] edge_o,
`endif
  output logic             busy_o
);

  logic [WIDTH-1:0] busy_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .rst     (rst),
      .d_i     (sw_i[i]),
      .stable_o(stable_o[i]),
      .busy_o  (busy_bits[i])
    );
  end

  assign busy_o = |busy_bits;

  // snapshot stage: holds for a whole slow-clock period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_o    <= '0;
      changed_o <= 1'b0;
    end else if (sample_i) begin
      gpio_o    <= stable_o;
      changed_o <= (stable_o != gpio_o);
    end
  end

`ifdef GPIO_EDGE_EN
  logic [WIDTH-1:0] stable_p1;
  logic [WIDTH-1:0] edge_sticky;
  logic [WIDTH-1:0] flip;

  // a flip shows up as a difference against last cycle's stable level
  assign flip = stable_o ^ stable_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_p1   <= '0;
      edge_sticky <= '0;
      edge_o      <= '0;
    end else begin
      stable_p1 <= stable_o;
      if (sample_i) begin
        edge_o      <= edge_sticky;
        edge_sticky <= flip;
      end else begin
        edge_sticky <= edge_sticky | flip;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce with WIDTH=8, DEBOUNCE_CYCLES=4.
module tb_gpio_in_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sw_i = 8'h00;
  logic       sample_i = 1'b0;
  logic [7:0] gpio_o;
  logic [7:0] stable_o;
  logic       changed_o;
  logic       busy_o;
`ifdef GPIO_EDGE_EN
  logic [7:0] edge_o;
`endif

  int total = 0;
  int bad   = 0;

  gpio_in_debounce #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_i     (sw_i),
    .sample_i (sample_i),
    .gpio_o   (gpio_o),
    .stable_o (stable_o),
    .changed_o(changed_o),
`ifdef GPIO_EDGE_EN
    .edge_o   (edge_o),
`endif
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sample();
    sample_i = 1'b1;
    tick();
    sample_i = 1'b0;
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_gpio", gpio_o, 8'h00);
    chk("rst_stable", stable_o, 8'h00);
    chk("rst_changed", {7'b0, changed_o}, 8'h00);
    chk("rst_busy", {7'b0, busy_o}, 8'h00);
    rst = 1'b1;
    tick();

    // 1: accept A5 exactly 6 clk after the change
    sw_i = 8'hA5;
    tick(2);
    chk("t1_busy_c2", {7'b0, busy_o}, 8'h00);
    tick();
    chk("t1_busy_c3", {7'b0, busy_o}, 8'h01);
    tick(2);
    chk("t1_busy_c5", {7'b0, busy_o}, 8'h01);
    chk("t1_stable_c5", stable_o, 8'h00);
    tick();
    chk("t1_stable_c6", stable_o, 8'hA5);
    chk("t1_busy_c6", {7'b0, busy_o}, 8'h00);
    sample();
    chk("t1_gpio", gpio_o, 8'hA5);
    chk("t1_changed", {7'b0, changed_o}, 8'h01);

    // 2: 3-clk glitch on bit0 is rejected
    sw_i = 8'hA4;
    tick(3);
    chk("t2_busy", {7'b0, busy_o}, 8'h01);
    sw_i = 8'hA5;
    tick(5);
    chk("t2_stable", stable_o, 8'hA5);
    chk("t2_busy_end", {7'b0, busy_o}, 8'h00);
    sample();
    chk("t2_gpio", gpio_o, 8'hA5);
    chk("t2_changed", {7'b0, changed_o}, 8'h00);

    // 3: sample coincident with the 00->01 flip takes the pre-flip value
    sw_i = 8'h00;
    tick(7);
    sample();
    sample();
    chk("t3_pre_gpio", gpio_o, 8'h00);
    chk("t3_pre_changed", {7'b0, changed_o}, 8'h00);
    sw_i = 8'h01;
    tick(5);
    sample_i = 1'b1;
    tick();
    sample_i = 1'b0;
    chk("t3_stable", stable_o, 8'h01);
    chk("t3_gpio_coinc", gpio_o, 8'h00);
    chk("t3_changed_coinc", {7'b0, changed_o}, 8'h00);
    tick(2);
    sample();
    chk("t3_gpio_next", gpio_o, 8'h01);
    chk("t3_changed_next", {7'b0, changed_o}, 8'h01);

    // 4: no input change between samples
    tick(3);
    sample();
    chk("t4_gpio", gpio_o, 8'h01);
    chk("t4_changed", {7'b0, changed_o}, 8'h00);

    // 5: asynchronous reset mid-debounce, then full re-acceptance
    sw_i = 8'h3C;
    tick(4);
    chk("t5_busy_mid", {7'b0, busy_o}, 8'h01);
    rst = 1'b0;
    #2;
    chk("t5_async_gpio", gpio_o, 8'h00);
    chk("t5_async_stable", stable_o, 8'h00);
    chk("t5_async_busy", {7'b0, busy_o}, 8'h00);
    tick(2);
    rst = 1'b1;
    tick(5);
    chk("t5_stable_c5", stable_o, 8'h00);
    tick();
    chk("t5_stable_c6", stable_o, 8'h3C);

`ifdef GPIO_EDGE_EN
    // 6: sticky edge flags copied on sample, cleared afterwards
    tick();
    sample();
    chk("t6_edge_accept", edge_o, 8'h3C);
    sample();
    chk("t6_edge_clear0", edge_o, 8'h00);
    sw_i = 8'h34;
    tick(8);
    sw_i = 8'h3C;
    tick(8);
    sw_i = 8'h34;
    tick(8);
    chk("t6_stable", stable_o, 8'h34);
    sample();
    chk("t6_edge_b3", edge_o, 8'h08);
    chk("t6_changed", {7'b0, changed_o}, 8'h01);
    tick(2);
    sample();
    chk("t6_edge_clear", edge_o, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
